seg7_scan_mux_pwm: RTL and testbench

//  Parametrised multiplexed 7-segment display driver for the mood-lighting front panel.
//  - Holds a DIGITS-deep ASCII character buffer that the host writes one character at a time.
//  - Scans the digits, one anode active at a time, and adds per-digit blink and global brightness PWM.
//  - Adds anti-ghost blanking at every digit change.
//  - Feeds the existing seg7_ascii decoder; replaces the fixed 8-digit "R/G/B" scan display.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/disp_scan_timer.sv | 70 +++++++
 rtl/seg7_ascii.sv | 68 ++++++
 rtl/seg7_scan_mux_pwm.sv | 113 +++++++++++
 tb/tb_seg7_scan_mux_pwm.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Package : disp_pkg
// Shared constants and anode helper for the multiplexed 7-segment driver.
// Rev     : 1.0  initial release
// ============================================================================
package disp_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [6:0] SEG_OFF     = 7'h7F;
  localparam int         MAX_DIGITS  = 16;

  typedef logic [MAX_DIGITS-1:0] an_vec_t;

  // Digit 0 is the leftmost position and maps to the highest anode bit.
  function automatic an_vec_t an_onehot_low(input int idx, input int n);
    an_vec_t v;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      v[i] = !((idx < n) && (i == n - 1 - idx));
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_scan_timer.sv
`default_nettype none
// ============================================================================
// Module : disp_scan_timer
// Slot prescaler, digit index, frame tick and blink phase for the scan driver.
// Rev    : 1.0  initial release
// ============================================================================
module disp_scan_timer #(
  parameter  int DIGITS       = 8,
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLINK_FRAMES = 64,
  localparam int PW           = $clog2(SCAN_DIV),
  localparam int IW           = $clog2(DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] o_cnt,
  output logic [IW-1:0] o_idx,
  output logic          o_frame_tick,
  output logic          o_blink_phase
);

  localparam int            FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [FW-1:0] r_frm;
  logic          r_frame_tick;
  logic          r_blink_phase;
  logic          w_slot_end;
  logic          w_frame_end;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frm         <= '0;
      r_frame_tick  <= 1'b0;
      r_blink_phase <= 1'b0;
    end else begin
      r_cnt        <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_frame_tick <= w_frame_end;
      if (w_slot_end) begin
        r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
      end
      // Blink phase flips once every BLINK_FRAMES complete frames.
      if (w_frame_end) begin
        if (r_frm == FRM_LAST) begin
          r_frm         <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frm <= r_frm + 1'b1;
        end
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_idx         = r_idx;
  assign o_frame_tick  = r_frame_tick;
  assign o_blink_phase = r_blink_phase;

endmodule

`default_nettype wire

// File: rtl/seg7_ascii.sv
`default_nettype none
// ============================================================================
// Module : seg7_ascii
// Combinational ASCII to active-low 7-segment decoder (bit order gfedcba).
// Rev    : 1.0  initial release
// ============================================================================
module seg7_ascii (
  input  logic [7:0] i_ascii,
  output logic [6:0] o_seg
);

  logic [7:0] w_up;
  logic [6:0] w_on;

  // Lower-case letters share the upper-case glyphs.
  always_comb begin
    w_up = i_ascii;
    if (i_ascii >= 8'h61 && i_ascii <= 8'h7A) begin
      w_up = i_ascii - 8'h20;
    end
  end

  always_comb begin
    w_on = 7'h00;
    case (w_up)
      8'h30: w_on = 7'h3F;
      8'h31: w_on = 7'h06;
      8'h32: w_on = 7'h5B;
      8'h33: w_on = 7'h4F;
      8'h34: w_on = 7'h66;
      8'h35: w_on = 7'h6D;
      8'h36: w_on = 7'h7D;
      8'h37: w_on = 7'h07;
      8'h38: w_on = 7'h7F;
      8'h39: w_on = 7'h6F;
      8'h41: w_on = 7'h77;
      8'h42: w_on = 7'h7C;
      8'h43: w_on = 7'h39;
      8'h44: w_on = 7'h5E;
      8'h45: w_on = 7'h79;
      8'h46: w_on = 7'h71;
      8'h47: w_on = 7'h3D;
      8'h48: w_on = 7'h76;
      8'h49: w_on = 7'h30;
      8'h4A: w_on = 7'h1E;
      8'h4C: w_on = 7'h38;
      8'h4E: w_on = 7'h54;
      8'h4F: w_on = 7'h3F;
      8'h50: w_on = 7'h73;
      8'h51: w_on = 7'h67;
      8'h52: w_on = 7'h50;
      8'h53: w_on = 7'h6D;
      8'h54: w_on = 7'h78;
      8'h55: w_on = 7'h3E;
      8'h59: w_on = 7'h6E;
      8'h5A: w_on = 7'h5B;
      8'h2D: w_on = 7'h40;
      8'h5F: w_on = 7'h08;
      8'h3D: w_on = 7'h48;
      default: w_on = 7'h00;
    endcase
  end

  assign o_seg = ~w_on;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_mux_pwm.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_mux_pwm
// Multiplexed 7-segment driver: character buffer, scan, blink, PWM dimming.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_scan_mux_pwm
  import disp_pkg::*;
#(
  parameter  int DIGITS       = 8,
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLANK        = 4,
  parameter  int DIM_BITS     = 3,
  parameter  int BLINK_FRAMES = 64,
  // One spare address bit so out-of-range indices are expressible and dropped.
  localparam int AW           = $clog2(DIGITS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [7:0]          wr_char,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic [DIM_BITS-1:0] bright,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_tick
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam int            IW         = $clog2(DIGITS);
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DIGITS);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);

  logic [7:0]          r_buf [DIGITS];
  logic [DIM_BITS-1:0] r_pwm;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;

  logic [PW-1:0]       w_cnt;
  logic [IW-1:0]       w_idx;
  logic                w_frame_tick;
  logic                w_blink_phase;
  logic [7:0]          w_char;
  logic [6:0]          w_seg_code;
  an_vec_t             w_an_full;
  logic                w_an_unused;
  logic                w_lit;

  disp_scan_timer #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .o_cnt         (w_cnt),
    .o_idx         (w_idx),
    .o_frame_tick  (w_frame_tick),
    .o_blink_phase (w_blink_phase)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_buf[i] <= ASCII_SPACE;
      end
    end else if (wr_en && (wr_addr < ADDR_LIMIT)) begin
      r_buf[wr_addr[IW-1:0]] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  assign w_char = r_buf[w_idx];

  seg7_ascii u_dec (
    .i_ascii (w_char),
    .o_seg   (w_seg_code)
  );

  assign w_an_full = an_onehot_low(int'(w_idx), DIGITS);
  // Positions above DIGITS are always high and are simply not driven out.
  assign w_an_unused = ^w_an_full;

  assign w_lit = (w_cnt >= BLANK_END)
              && (r_pwm <= bright)
              && !(blink_mask[w_idx] && w_blink_phase);

  // seg and an share one register stage so they never skew.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_lit ? w_an_full[DIGITS-1:0] : '1;
      r_seg <= w_lit ? w_seg_code : SEG_OFF;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_tick = w_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux_pwm.sv
`default_nettype none
// ============================================================================
// Module : tb_seg7_scan_mux_pwm
// Self-checking bench: closed-form scan model feeding a scoreboard, plus
// table-driven duty/blink vectors and hand sequences for write and reset.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_mux_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_char;
  logic [3:0] blink_mask;
  logic [1:0] bright;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_mux_pwm #(
    .DIGITS       (4),
    .SCAN_DIV     (16),
    .BLANK        (2),
    .DIM_BITS     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .blink_mask (blink_mask),
    .bright     (bright),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  typedef struct {
    logic [1:0] br;
    logic [3:0] mk;
    int         d0;
    int         d3;
    int         ft;
  } vec_t;

  exp_t       sb_q[$];
  logic [7:0] mbuf [4];
  int         m_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] code(input logic [7:0] c);
    case (c)
      8'h52:   return 7'h2F;
      8'h31:   return 7'h79;
      8'h47:   return 7'h42;
      8'h32:   return 7'h24;
      8'h39:   return 7'h10;
      8'h38:   return 7'h00;
      default: return 7'h7F;
    endcase
  endfunction

  // Output after the edge that consumes state number t since reset release.
  function automatic exp_t model(input int t);
    exp_t       e;
    int         cnt, idx, pwm, ph;
    logic       lit;
    logic [3:0] pos;
    cnt = t % 16;
    idx = (t / 16) % 4;
    pwm = t % 4;
    ph  = (t / 128) % 2;
    lit = (cnt >= 2) && (pwm <= int'(bright)) && !(blink_mask[idx] && (ph == 1));
    pos = 4'b1000 >> idx;
    e.an  = lit ? ~pos : 4'hF;
    e.seg = lit ? code(mbuf[idx]) : 7'h7F;
    e.ft  = ((t % 64) == 63);
    return e;
  endfunction

  initial begin : scoreboard
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_t = 0;
        for (int i = 0; i < 4; i++) mbuf[i] = 8'h20;
        sb_q.delete();
      end else begin
        sb_q.push_back(model(m_t));
        if (wr_en && (wr_addr < 3'd4)) mbuf[wr_addr[1:0]] = wr_char;
        m_t++;
        @(negedge clk);
        if (rst && (sb_q.size() > 0)) begin
          e = sb_q.pop_front();
          chk("sb_an", int'(an), int'(e.an));
          chk("sb_seg", int'(seg), int'(e.seg));
          chk("sb_frame_tick", int'(frame_tick), int'(e.ft));
        end else begin
          sb_q.delete();
        end
      end
    end
  end

  task automatic wait_an(input logic [3:0] tgt, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((an !== tgt) && (k < 200));
    chk(name, int'(an), int'(tgt));
  endtask

  task automatic write_char(input logic [2:0] a, input logic [7:0] c);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin : main
    vec_t vecs[6];
    int   k, c0, c3, cft, bad;

    vecs[0] = '{br: 2'd3, mk: 4'b0000, d0: 56, d3: 56, ft: 4};
    vecs[1] = '{br: 2'd2, mk: 4'b0000, d0: 40, d3: 40, ft: 4};
    vecs[2] = '{br: 2'd1, mk: 4'b0000, d0: 24, d3: 24, ft: 4};
    vecs[3] = '{br: 2'd0, mk: 4'b0000, d0: 12, d3: 12, ft: 4};
    vecs[4] = '{br: 2'd3, mk: 4'b0001, d0: 28, d3: 56, ft: 4};
    vecs[5] = '{br: 2'd2, mk: 4'b1001, d0: 20, d3: 20, ft: 4};

    wr_en = 1'b0; wr_addr = '0; wr_char = 8'h00;
    blink_mask = 4'b0000; bright = 2'd3;

    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", int'(an), 32'hF);
    chk("reset_seg", int'(seg), 32'h7F);
    chk("reset_frame_tick", int'(frame_tick), 0);
    rst = 1'b1;

    // Frame tick period from release, then between ticks
    k = 0;
    do begin @(negedge clk); k++; end while (!frame_tick && k < 200);
    chk("first_frame_tick_clk", k, 64);
    k = 0;
    do begin @(negedge clk); k++; end while (!frame_tick && k < 200);
    chk("frame_tick_period", k, 64);

    // Load "R1G2"
    write_char(3'd0, 8'h52);
    write_char(3'd1, 8'h31);
    write_char(3'd2, 8'h47);
    write_char(3'd3, 8'h32);
    repeat (64) @(negedge clk);
    wait_an(4'b0111, "wait_digit0");
    chk("digit0_seg_R", int'(seg), 32'h2F);
    wait_an(4'b1110, "wait_digit3");
    chk("digit3_seg_2", int'(seg), 32'h24);

    // Duty and blink vectors over one 256-clk blink period
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      bright = vecs[v].br; blink_mask = vecs[v].mk;
      c0 = 0; c3 = 0; cft = 0; bad = 0;
      repeat (256) begin
        @(negedge clk);
        if (an == 4'b0111) c0++;
        if (an == 4'b1110) c3++;
        if (frame_tick) cft++;
        if (!(an inside {4'hF, 4'h7, 4'hB, 4'hD, 4'hE})) bad++;
      end
      chk($sformatf("vec%0d_digit0_lit", v), c0, vecs[v].d0);
      chk($sformatf("vec%0d_digit3_lit", v), c3, vecs[v].d3);
      chk($sformatf("vec%0d_frame_ticks", v), cft, vecs[v].ft);
      chk($sformatf("vec%0d_illegal_an", v), bad, 0);
    end

    @(negedge clk);
    bright = 2'd3; blink_mask = 4'b0000;

    // Out-of-range address must not touch the buffer
    write_char(3'd5, 8'h38);
    wait_an(4'b0111, "wait_digit0_b");
    wait_an(4'b1011, "wait_digit1");
    chk("addr5_ignored", int'(seg), 32'h79);

    // Write to the digit on display: old glyph for one more clk, then new
    wr_en = 1'b1; wr_addr = 3'd1; wr_char = 8'h39;
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_lat_1clk_old", int'(seg), 32'h79);
    @(negedge clk);
    chk("wr_lat_2clk_new", int'(seg), 32'h10);
    chk("wr_lat_same_digit", int'(an), 32'hB);

    // Asynchronous reset mid-slot
    wait_an(4'b1101, "wait_digit2");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midreset_an", int'(an), 32'hF);
    chk("midreset_seg", int'(seg), 32'h7F);
    chk("midreset_frame_tick", int'(frame_tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while ((an === 4'hF) && k < 20);
    chk("restart_latency", k, 3);
    chk("restart_digit0", int'(an), 32'h7);
    chk("restart_buffer_space", int'(seg), 32'h7F);
    repeat (80) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
